// File: rtl/soc_system_key_pio.sv
// Avalon-MM input PIO: synchronise, debounce and edge-capture key/switch lines, masked level IRQ.
// Latency: in_port -> DATA after 1+DEBOUNCE_CYCLES clk edges; reads are combinational (zero wait states).
// Backpressure: none; the slave accepts every access in the cycle it is presented.
//
// Ports:
//   clk, reset_n        : single clock, asynchronous active-low reset
//   address[1:0]        : word address (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP)
//   chipselect, write_n : a write happens on a clk edge where chipselect && !write_n
//   writedata[31:0]     : write data (IRQMASK value, or EDGECAP clear mask)
//   in_port[WIDTH-1:0]  : raw asynchronous input lines
//   readdata[31:0]      : read data, combinational from address, upper bits zero
//   irq                 : level interrupt, |(edgecap & irqmask)
module soc_system_key_pio #(
  parameter int   WIDTH           = 4,
  parameter int   EDGE_TYPE       = 1,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE   = {WIDTH{IDLE_LEVEL}};

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bit debounce. The counter only runs while the synchronised level
  // disagrees with the accepted level; any return to agreement restarts it,
  // so a glitch must persist DEBOUNCE_CYCLES consecutive cycles to be taken.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_nxt;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];

  always_comb begin
    deb_nxt = deb;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (sync2[i] == deb[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        deb_nxt[i] = sync2[i];
        cnt_nxt[i] = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb <= IDLE;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      deb <= deb_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Edge events, derived from the debounced level about to be loaded so the
  // event lands in edgecap on the same edge that deb changes.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] ev;

  always_comb begin
    if (EDGE_TYPE == 0) begin
      ev = ~deb & deb_nxt;
    end else if (EDGE_TYPE == 1) begin
      ev = deb & ~deb_nxt;
    end else begin
      ev = deb ^ deb_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic             wr_en;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] edgecap_clr;

  assign wr_en       = chipselect && !write_n;
  assign edgecap_clr = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
      edgecap <= '0;
    end else begin
      if (wr_en && address == ADDR_IRQMASK) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      // A new event beats a simultaneous W1C so no edge is ever lost.
      edgecap <= (edgecap & ~edgecap_clr) | ev;
    end
  end

  assign irq = |(edgecap & irqmask);

  // Reads have no side effects, so chipselect is not needed to decode them.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = deb;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
      default:      readdata = '0;
    endcase
  end

  // Write data above WIDTH has no destination.
  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

endmodule

// File: tb/tb_soc_system_key_pio.sv
module tb_soc_system_key_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  soc_system_key_pio #(
    .WIDTH(4),
    .EDGE_TYPE(1),
    .DEBOUNCE_CYCLES(4),
    .IDLE_LEVEL(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs set afterwards are sampled on the following one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // The write takes effect on the next rising edge; returns 1ns after it.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    in_port = 4'hF;
    ticks(3);
    reset_n = 1'b1;
    tick();
    rd(2'd0, d);
    if (d !== 32'h0000_000F) begin $display("FAIL reset_data got %h exp %h", d, 32'hF); n_bad++; end
    n_cmp++;
    rd(2'd1, d);
    if (d !== 32'h0) begin $display("FAIL reset_rsvd got %h exp %h", d, 32'h0); n_bad++; end
    n_cmp++;
    rd(2'd2, d);
    if (d !== 32'h0) begin $display("FAIL reset_mask got %h exp %h", d, 32'h0); n_bad++; end
    n_cmp++;
    rd(2'd3, d);
    if (d !== 32'h0) begin $display("FAIL reset_ecap got %h exp %h", d, 32'h0); n_bad++; end
    n_cmp++;
    if (irq !== 1'b0) begin $display("FAIL reset_irq got %b exp 0", irq); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_regmap();
    logic [31:0] d;
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, d);
    if (d !== 32'h0) begin $display("FAIL rsvd_write got %h exp %h", d, 32'h0); n_bad++; end
    n_cmp++;
    wr(2'd0, 32'h0000_0000);
    rd(2'd0, d);
    if (d !== 32'hF) begin $display("FAIL data_write got %h exp %h", d, 32'hF); n_bad++; end
    n_cmp++;
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, d);
    if (d !== 32'hF) begin $display("FAIL mask_upper got %h exp %h", d, 32'hF); n_bad++; end
    n_cmp++;
    wr(2'd2, 32'h0);
    rd(2'd2, d);
    if (d !== 32'h0) begin $display("FAIL mask_zero got %h exp %h", d, 32'h0); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    in_port = 4'hE;           // first sampled at edge k
    for (int n = 1; n <= 5; n++) begin
      tick();                 // just past edge k+n-1
      rd(2'd0, d);
      if (d !== 32'hF) begin $display("FAIL deb_early_data n=%0d got %h exp %h", n, d, 32'hF); n_bad++; end
      n_cmp++;
      rd(2'd3, d);
      if (d !== 32'h0) begin $display("FAIL deb_early_ecap n=%0d got %h exp %h", n, d, 32'h0); n_bad++; end
      n_cmp++;
    end
    tick();                   // just past edge k+5
    rd(2'd0, d);
    if (d !== 32'hE) begin $display("FAIL deb_data got %h exp %h", d, 32'hE); n_bad++; end
    n_cmp++;
    rd(2'd3, d);
    if (d !== 32'h1) begin $display("FAIL deb_ecap got %h exp %h", d, 32'h1); n_bad++; end
    n_cmp++;
    if (irq !== 1'b0) begin $display("FAIL deb_irq_masked got %b exp 0", irq); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    in_port = 4'hC;
    ticks(3);
    in_port = 4'hE;
    ticks(10);
    rd(2'd0, d);
    if (d !== 32'hE) begin $display("FAIL glitch3_data got %h exp %h", d, 32'hE); n_bad++; end
    n_cmp++;
    rd(2'd3, d);
    if (d !== 32'h1) begin $display("FAIL glitch3_ecap got %h exp %h", d, 32'h1); n_bad++; end
    n_cmp++;
    in_port = 4'hC;
    ticks(5);
    in_port = 4'hE;
    ticks(12);
    rd(2'd3, d);
    if (d !== 32'h3) begin $display("FAIL pulse5_ecap got %h exp %h", d, 32'h3); n_bad++; end
    n_cmp++;
    rd(2'd0, d);
    if (d !== 32'hE) begin $display("FAIL pulse5_data got %h exp %h", d, 32'hE); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_irq();
    logic [31:0] d;
    if (irq !== 1'b0) begin $display("FAIL irq_pre got %b exp 0", irq); n_bad++; end
    n_cmp++;
    wr(2'd2, 32'h1);
    if (irq !== 1'b1) begin $display("FAIL irq_unmask got %b exp 1", irq); n_bad++; end
    n_cmp++;
    wr(2'd3, 32'h1);
    rd(2'd3, d);
    if (d !== 32'h2) begin $display("FAIL w1c_ecap got %h exp %h", d, 32'h2); n_bad++; end
    n_cmp++;
    if (irq !== 1'b0) begin $display("FAIL w1c_irq got %b exp 0", irq); n_bad++; end
    n_cmp++;
    wr(2'd2, 32'h2);
    if (irq !== 1'b1) begin $display("FAIL irq_mask2 got %b exp 1", irq); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_set_beats_clear();
    logic [31:0] d;
    in_port = 4'hF;           // rising on bit 0 is not captured
    ticks(10);
    rd(2'd0, d);
    if (d !== 32'hF) begin $display("FAIL rise0_data got %h exp %h", d, 32'hF); n_bad++; end
    n_cmp++;
    rd(2'd3, d);
    if (d !== 32'h2) begin $display("FAIL rise0_ecap got %h exp %h", d, 32'h2); n_bad++; end
    n_cmp++;
    wr(2'd2, 32'h1);
    if (irq !== 1'b0) begin $display("FAIL collide_pre_irq got %b exp 0", irq); n_bad++; end
    n_cmp++;
    in_port = 4'hE;           // sampled at edge k, deb falls at edge k+5
    ticks(5);                 // just past edge k+4
    wr(2'd3, 32'h1);          // W1C lands on edge k+5
    rd(2'd3, d);
    if (d !== 32'h3) begin $display("FAIL collide_ecap got %h exp %h", d, 32'h3); n_bad++; end
    n_cmp++;
    if (irq !== 1'b1) begin $display("FAIL collide_irq got %b exp 1", irq); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_rising_ignored();
    logic [31:0] d;
    in_port = 4'hF;
    ticks(10);
    rd(2'd0, d);
    if (d !== 32'hF) begin $display("FAIL rise_data got %h exp %h", d, 32'hF); n_bad++; end
    n_cmp++;
    rd(2'd3, d);
    if (d !== 32'h3) begin $display("FAIL rise_ecap got %h exp %h", d, 32'h3); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] d;
    in_port = 4'h6;           // bits 0 and 3 pressed
    ticks(3);                 // counters running, not yet complete
    reset_n = 1'b0;
    #2;
    if (irq !== 1'b0) begin $display("FAIL arst_irq got %b exp 0", irq); n_bad++; end
    n_cmp++;
    tick();
    reset_n = 1'b1;           // press still held; must re-qualify from idle
    rd(2'd0, d);
    if (d !== 32'hF) begin $display("FAIL rst_mid_data got %h exp %h", d, 32'hF); n_bad++; end
    n_cmp++;
    rd(2'd2, d);
    if (d !== 32'h0) begin $display("FAIL rst_mid_mask got %h exp %h", d, 32'h0); n_bad++; end
    n_cmp++;
    rd(2'd3, d);
    if (d !== 32'h0) begin $display("FAIL rst_mid_ecap got %h exp %h", d, 32'h0); n_bad++; end
    n_cmp++;
    ticks(5);                 // just past edge k+4 after release
    rd(2'd0, d);
    if (d !== 32'hF) begin $display("FAIL requal_early got %h exp %h", d, 32'hF); n_bad++; end
    n_cmp++;
    tick();                   // just past edge k+5
    rd(2'd0, d);
    if (d !== 32'h6) begin $display("FAIL requal_data got %h exp %h", d, 32'h6); n_bad++; end
    n_cmp++;
    rd(2'd3, d);
    if (d !== 32'h9) begin $display("FAIL requal_ecap got %h exp %h", d, 32'h9); n_bad++; end
    n_cmp++;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    test_reset();
    test_regmap();
    test_debounce();
    test_glitch();
    test_irq();
    test_set_beats_clear();
    test_rising_ignored();
    test_reset_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/soc_system_key_pio.md
Name: soc_system_key_pio

Overview:
Avalon-MM slave input PIO. It samples external pushbutton/switch lines, synchronises and debounces them, and latches selected edges into an edge-capture register. A masked interrupt is raised to the HPS/Nios from that register. It is the input-direction companion of the LED output PIO and shares its bus timing: zero-wait-state reads, 2-bit word address.

Parameters:
WIDTH, 4, number of input lines (1..32)
EDGE_TYPE, 1, capture edge: 0 rising, 1 falling, 2 any
DEBOUNCE_CYCLES, 50000, cycles a synchronised level must hold before acceptance (minimum 1; 1 means no filtering)
IDLE_LEVEL, 1'b1, reset value of every synchroniser and debounce bit (keys are active-low)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
in_port  in  WIDTH  raw asynchronous input lines
readdata  out  32  read data, combinational from address
irq  out  1  interrupt request, active-high level

Behaviour:
- Clock and reset: clk is the only clock. reset_n is asynchronous and active-low.
- Reset values:
  - sync1, sync2 and deb (debounced) registers = {WIDTH{IDLE_LEVEL}}.
  - Per-bit counters = 0.
  - irqmask = 0, edgecap = 0, irq = 0.
  - readdata follows the address decode, so after reset address 0 reads the idle value.
- Synchroniser: two flops per bit. in_port stable from edge k appears in sync2 after edge k+1.
- Debounce, per bit i:
  - If sync2[i]==deb[i], cnt[i] <= 0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1, deb[i] <= sync2[i] and cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - Result: a held change at edge k updates deb at edge k+1+DEBOUNCE_CYCLES.
  - A pulse shorter than DEBOUNCE_CYCLES synchronised cycles is discarded.
  - Counter width = $clog2(DEBOUNCE_CYCLES+1).
- Edge event: ev[i] asserts on the same edge where deb[i] updates, qualified by EDGE_TYPE.
  - Rising: deb 0->1.
  - Falling: deb 1->0.
  - Any: either direction.
- Register map (word address):
  - 0, DATA: read-only, {0, deb}. Writes ignored.
  - 1, reserved: reads 0, writes ignored.
  - 2, IRQMASK: read/write, bits [WIDTH-1:0]. Upper bits read 0.
  - 3, EDGECAP: read; a write clears bits where writedata is 1 (W1C).
- Write qualifier: chipselect && !write_n. The register updates on that clk edge.
- EDGECAP next state: (edgecap & ~clr) | ev. A set in the same cycle as a clear wins, so the bit stays 1.
- Reads: readdata is valid in the same cycle as address (read latency 0) and has no side effects. Reading EDGECAP does not clear it.
- irq = |(edgecap & irqmask).
  - Asserts the cycle after the edge that sets edgecap, or after the IRQMASK write that unmasks a pending bit.
  - Deasserts after a W1C or mask write removes the last pending bit.
- Reset mid-debounce or mid-event: counters are aborted and all state returns to reset values. A pressed key is then re-qualified from idle.
- Unused upper readdata bits are always 0.

Test Plan:
(Bench parameters: WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, IDLE_LEVEL=1.)
- Reset, in_port=4'hF, read all four addresses -> 0x0000000F, 0, 0, 0; irq=0.
- in_port=4'hE from edge k and held -> DATA reads 0xE and EDGECAP reads 0x1 from edge k+5; irq stays 0 (mask 0). Neither changes before edge k+5.
- in_port[1] low for 3 cycles then high -> DATA stays 0xE and EDGECAP stays 0x1. Low for 5 cycles -> EDGECAP = 0x3.
- Write IRQMASK=0x1 -> irq=1 the cycle after the write edge. Write EDGECAP=0x1 -> EDGECAP=0x2 and irq=0. Write IRQMASK=0x2 -> irq=1.
- Time the bit-0 debounce to complete (a falling event) on the same edge as a write of EDGECAP=0x1 -> bit 0 reads 1 and irq remains asserted.
- in_port back to 4'hF -> DATA=0xF with no new EDGECAP bits (rising edges are ignored).
- Assert reset_n low mid-count, then release -> all registers read reset values and irq=0.
